// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART memory loader.
package loader_pkg;

    // States of the serial bit receiver
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Word-level loader states: still accepting words, or end marker seen
    typedef enum logic {
        LD_LOADING,
        LD_DONE
    } loader_state_t;

    // Number of system clocks spanned by one serial bit
    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

    // End-of-load marker: a word of all ones, returned in the low 8*word_bytes bits
    function automatic logic [63:0] end_marker(input int word_bytes);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < 8 * word_bytes) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: line synchronizer, baud counter and bit-level FSM.
// Emits a one-cycle byte_valid with the received byte and an error flag
// for a low stop bit or (when enabled) an even-parity mismatch.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic      rx_meta;
    logic      rx_sync;
    logic      rx_prev;
    rx_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bad;

    assign busy = (state != RX_IDLE);

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit FSM: find start edge, confirm at half bit, then sample each bit mid-period
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                            par_bad <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY_EN ? RX_PARITY : RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bad <= (rx_sync != ^shift);
                        state   <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        byte_valid <= 1'b1;
                        byte_data  <= shift;
                        byte_err   <= !rx_sync || par_bad;
                        state      <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a memory image received over UART: bytes are packed little-endian
// into words, each complete word is written to consecutive addresses, and an
// all-ones word ends the load.
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter bit PARITY_EN   = 1'b0
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      rx_serial,
    input  logic                      restart,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [8*WORD_BYTES-1:0]   mem_wdata,
    output logic                      load_done,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [ADDR_WIDTH:0]       word_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int WORD_W       = 8 * WORD_BYTES;
    localparam int PW           = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [WORD_W-1:0]   END_MARKER = WORD_W'(end_marker(WORD_BYTES));
    localparam logic [PW-1:0]       LAST_POS   = PW'(WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_err;
    logic          rx_busy;

    loader_state_t ld_state;
    logic [PW-1:0]     byte_pos;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] next_word;
    logic              write_is_marker;
    logic              discard;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_EN    (PARITY_EN)
    ) u_rx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .busy       (rx_busy)
    );

    // Word being assembled with the incoming byte dropped into its lane
    always_comb begin
        next_word = word_buf;
        next_word[{byte_pos, 3'b000} +: 8] = byte_data;
    end

    // Word assembly, write strobe, address/count tracking and sticky status
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ld_state        <= LD_LOADING;
            byte_pos        <= '0;
            word_buf        <= '0;
            write_is_marker <= 1'b0;
            discard         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            load_done       <= 1'b0;
            frame_err       <= 1'b0;
            overflow        <= 1'b0;
            word_count      <= '0;
        end else begin
            mem_we <= 1'b0;

            // The cycle after a write advances the address; it parks on the
            // last location instead of wrapping once the space is full.
            if (mem_we) begin
                word_count <= word_count + 1'b1;
                if (word_count != LAST_COUNT) begin
                    mem_addr <= mem_addr + 1'b1;
                end
                if (write_is_marker) begin
                    load_done <= 1'b1;
                    ld_state  <= LD_DONE;
                end
            end

            if (restart) begin
                // A byte already in flight will still arrive; drop it when it does.
                ld_state   <= LD_LOADING;
                byte_pos   <= '0;
                mem_addr   <= '0;
                word_count <= '0;
                load_done  <= 1'b0;
                frame_err  <= 1'b0;
                overflow   <= 1'b0;
                discard    <= rx_busy;
            end else if (byte_valid) begin
                if (discard) begin
                    discard <= 1'b0;
                end else if (byte_err) begin
                    frame_err <= 1'b1;
                end else if (ld_state == LD_LOADING) begin
                    if (byte_pos == LAST_POS) begin
                        byte_pos <= '0;
                        if (word_count == FULL_COUNT) begin
                            overflow <= 1'b1;
                        end else begin
                            mem_we          <= 1'b1;
                            mem_wdata       <= next_word;
                            write_is_marker <= (next_word == END_MARKER);
                        end
                    end else begin
                        byte_pos <= byte_pos + 1'b1;
                        word_buf <= next_word;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed self-checking bench for uart_mem_loader. Three instances cover the
// default configuration, a 2-bit address space and even parity. The baud rate
// is scaled to 8 clocks per bit so the whole run stays short.
module tb_uart_mem_loader;

    localparam int CLK_HZ    = 100_000_000;
    localparam int BAUD_RATE = 12_500_000;
    localparam int BIT_NS    = 80;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic restart = 1'b0;
    logic rx_a    = 1'b1;
    logic rx_b    = 1'b1;
    logic rx_c    = 1'b1;

    logic        we_a, done_a, ferr_a, ovf_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] cnt_a;

    logic        we_b, done_b, ferr_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;

    logic        we_c, done_c, ferr_c, ovf_c;
    logic [9:0]  addr_c;
    logic [31:0] wdata_c;
    logic [10:0] cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_cnt_a = 0, wr_cnt_b = 0, wr_cnt_c = 0;
    logic [31:0] last_data_a = '0, last_data_b = '0, last_data_c = '0;
    logic [9:0]  last_addr_a = '0, last_addr_c = '0;
    logic [1:0]  last_addr_b = '0;
    logic        prev_we_a = 1'b0, prev_we_b = 1'b0, prev_we_c = 1'b0;
    int          consec = 0;

    always #5 sys_clk = ~sys_clk;

    uart_mem_loader #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD (BAUD_RATE), .WORD_BYTES (4),
        .ADDR_WIDTH (10), .PARITY_EN (1'b0)
    ) dut_a (
        .sys_clk (sys_clk), .rst (rst), .rx_serial (rx_a), .restart (restart),
        .mem_we (we_a), .mem_addr (addr_a), .mem_wdata (wdata_a),
        .load_done (done_a), .frame_err (ferr_a), .overflow (ovf_a), .word_count (cnt_a)
    );

    uart_mem_loader #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD (BAUD_RATE), .WORD_BYTES (4),
        .ADDR_WIDTH (2), .PARITY_EN (1'b0)
    ) dut_b (
        .sys_clk (sys_clk), .rst (rst), .rx_serial (rx_b), .restart (restart),
        .mem_we (we_b), .mem_addr (addr_b), .mem_wdata (wdata_b),
        .load_done (done_b), .frame_err (ferr_b), .overflow (ovf_b), .word_count (cnt_b)
    );

    uart_mem_loader #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD (BAUD_RATE), .WORD_BYTES (4),
        .ADDR_WIDTH (10), .PARITY_EN (1'b1)
    ) dut_c (
        .sys_clk (sys_clk), .rst (rst), .rx_serial (rx_c), .restart (restart),
        .mem_we (we_c), .mem_addr (addr_c), .mem_wdata (wdata_c),
        .load_done (done_c), .frame_err (ferr_c), .overflow (ovf_c), .word_count (cnt_c)
    );

    // Record every write strobe and flag any back-to-back strobes
    always @(negedge sys_clk) begin
        if (we_a) begin
            wr_cnt_a++;
            last_addr_a = addr_a;
            last_data_a = wdata_a;
            if (prev_we_a) consec++;
        end
        if (we_b) begin
            wr_cnt_b++;
            last_addr_b = addr_b;
            last_data_b = wdata_b;
            if (prev_we_b) consec++;
        end
        if (we_c) begin
            wr_cnt_c++;
            last_addr_c = addr_c;
            last_data_c = wdata_c;
            if (prev_we_c) consec++;
        end
        prev_we_a = we_a;
        prev_we_b = we_b;
        prev_we_c = we_c;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setLine(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // One UART frame; the parity bit is only sent to the parity-enabled instance
    task automatic applyStimulus(input int which, input logic [7:0] data,
                                 input logic stop_bit, input logic par_bit);
        @(negedge sys_clk);
        setLine(which, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            setLine(which, data[i]);
            #(BIT_NS);
        end
        if (which == 2) begin
            setLine(which, par_bit);
            #(BIT_NS);
        end
        setLine(which, stop_bit);
        #(BIT_NS);
        setLine(which, 1'b1);
        #(2 * BIT_NS);
    endtask

    task automatic sendWord(input int which, input logic [31:0] w);
        applyStimulus(which, w[7:0],   1'b1, 1'b0);
        applyStimulus(which, w[15:8],  1'b1, 1'b0);
        applyStimulus(which, w[23:16], 1'b1, 1'b0);
        applyStimulus(which, w[31:24], 1'b1, 1'b0);
    endtask

    task automatic pulseRestart();
        @(negedge sys_clk);
        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
    endtask

    initial begin
        $display("[TB] Starting uart_mem_loader bench");
        repeat (5) @(negedge sys_clk);

        // Outputs while reset is held
        checkOutput("rst_we",    64'(we_a),    64'd0);
        checkOutput("rst_addr",  64'(addr_a),  64'd0);
        checkOutput("rst_wdata", 64'(wdata_a), 64'd0);
        checkOutput("rst_done",  64'(done_a),  64'd0);
        checkOutput("rst_ferr",  64'(ferr_a),  64'd0);
        checkOutput("rst_ovf",   64'(ovf_a),   64'd0);
        checkOutput("rst_count", 64'(cnt_a),   64'd0);
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Short low glitch must be rejected quietly
        rx_a = 1'b0;
        #20;
        rx_a = 1'b1;
        #(4 * BIT_NS);
        checkOutput("glitch_ferr",   64'(ferr_a),   64'd0);
        checkOutput("glitch_writes", 64'(wr_cnt_a), 64'd0);

        // First word 0x00100093
        sendWord(0, 32'h0010_0093);
        checkOutput("w0_writes", 64'(wr_cnt_a),    64'd1);
        checkOutput("w0_addr",   64'(last_addr_a), 64'd0);
        checkOutput("w0_data",   64'(last_data_a), 64'h0010_0093);
        checkOutput("w0_count",  64'(cnt_a),       64'd1);

        // Second word with a bad-stop byte between bytes 2 and 3
        applyStimulus(0, 8'h13, 1'b1, 1'b0);
        applyStimulus(0, 8'h05, 1'b1, 1'b0);
        applyStimulus(0, 8'hAA, 1'b0, 1'b0);
        checkOutput("ferr_set",     64'(ferr_a),   64'd1);
        checkOutput("ferr_nowrite", 64'(wr_cnt_a), 64'd1);
        applyStimulus(0, 8'h00, 1'b1, 1'b0);
        applyStimulus(0, 8'h00, 1'b1, 1'b0);
        checkOutput("w1_writes", 64'(wr_cnt_a),    64'd2);
        checkOutput("w1_addr",   64'(last_addr_a), 64'd1);
        checkOutput("w1_data",   64'(last_data_a), 64'h0000_0513);

        // Third word, then the end marker
        sendWord(0, 32'hDEAD_BEEF);
        checkOutput("w2_addr", 64'(last_addr_a), 64'd2);
        checkOutput("w2_data", 64'(last_data_a), 64'hDEAD_BEEF);
        checkOutput("w2_done", 64'(done_a),      64'd0);
        sendWord(0, 32'hFFFF_FFFF);
        checkOutput("mk_writes", 64'(wr_cnt_a),    64'd4);
        checkOutput("mk_addr",   64'(last_addr_a), 64'd3);
        checkOutput("mk_data",   64'(last_data_a), 64'hFFFF_FFFF);
        checkOutput("mk_done",   64'(done_a),      64'd1);
        checkOutput("mk_count",  64'(cnt_a),       64'd4);

        // Bytes after the marker are never written
        applyStimulus(0, 8'h13, 1'b1, 1'b0);
        checkOutput("done_nowrite", 64'(wr_cnt_a), 64'd4);
        checkOutput("done_hold",    64'(done_a),   64'd1);

        // Restart in the middle of a byte: status clears, that byte is dropped
        fork
            applyStimulus(0, 8'h77, 1'b1, 1'b0);
            begin
                #300;
                pulseRestart();
            end
        join
        checkOutput("rs_done",  64'(done_a), 64'd0);
        checkOutput("rs_ferr",  64'(ferr_a), 64'd0);
        checkOutput("rs_count", 64'(cnt_a),  64'd0);
        checkOutput("rs_addr",  64'(addr_a), 64'd0);
        sendWord(0, 32'h1122_3344);
        checkOutput("rs_writes", 64'(wr_cnt_a),    64'd5);
        checkOutput("rs_waddr",  64'(last_addr_a), 64'd0);
        checkOutput("rs_wdata",  64'(last_data_a), 64'h1122_3344);

        // Reset during the second byte of a word: partial word is lost
        applyStimulus(0, 8'h55, 1'b1, 1'b0);
        fork
            applyStimulus(0, 8'hFE, 1'b1, 1'b0);
            begin
                #200;
                @(negedge sys_clk);
                rst = 1'b1;
                @(negedge sys_clk);
                checkOutput("mr_we",    64'(we_a),    64'd0);
                checkOutput("mr_addr",  64'(addr_a),  64'd0);
                checkOutput("mr_wdata", 64'(wdata_a), 64'd0);
                checkOutput("mr_count", 64'(cnt_a),   64'd0);
                rst = 1'b0;
            end
        join
        checkOutput("mr_nowrite", 64'(wr_cnt_a), 64'd5);
        sendWord(0, 32'hD4C3_B2A1);
        checkOutput("mr_writes", 64'(wr_cnt_a),    64'd6);
        checkOutput("mr_waddr",  64'(last_addr_a), 64'd0);
        checkOutput("mr_wdata",  64'(last_data_a), 64'hD4C3_B2A1);

        // Two-bit address space: four writes fit, the fifth overflows
        for (int k = 1; k <= 4; k++) begin
            sendWord(1, 32'(k));
        end
        checkOutput("ao_writes4", 64'(wr_cnt_b),    64'd4);
        checkOutput("ao_addr4",   64'(last_addr_b), 64'd3);
        checkOutput("ao_data4",   64'(last_data_b), 64'h4);
        checkOutput("ao_ovf4",    64'(ovf_b),       64'd0);
        checkOutput("ao_count4",  64'(cnt_b),       64'd4);
        sendWord(1, 32'h5);
        checkOutput("ao_writes5", 64'(wr_cnt_b), 64'd4);
        checkOutput("ao_ovf5",    64'(ovf_b),    64'd1);
        checkOutput("ao_count5",  64'(cnt_b),    64'd4);
        checkOutput("ao_addr5",   64'(addr_b),   64'd3);

        // Even parity: 0x01 needs parity bit 1
        applyStimulus(2, 8'h01, 1'b1, 1'b0);
        checkOutput("par_bad_ferr",  64'(ferr_c),   64'd1);
        checkOutput("par_bad_write", 64'(wr_cnt_c), 64'd0);
        applyStimulus(2, 8'h01, 1'b1, 1'b1);
        applyStimulus(2, 8'h02, 1'b1, 1'b1);
        applyStimulus(2, 8'h03, 1'b1, 1'b0);
        applyStimulus(2, 8'h04, 1'b1, 1'b1);
        checkOutput("par_writes", 64'(wr_cnt_c),    64'd1);
        checkOutput("par_addr",   64'(last_addr_c), 64'd0);
        checkOutput("par_data",   64'(last_data_c), 64'h0403_0201);

        checkOutput("no_consec_we", 64'(consec), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (868 at defaults).
REQ-003 Parameter WORD_BYTES, default 4, bytes per memory word (1..8).
REQ-004 Parameter ADDR_WIDTH, default 10, word-address width.
REQ-005 Parameter PARITY_EN, default 0; 1 = even parity bit expected after data bits.
REQ-006 sys_clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 rx_serial  input  1  asynchronous UART line, idle high, 8N1 (8E1 if PARITY_EN).
REQ-009 restart  input  1  single-cycle pulse: clear address and status, re-arm loading.
REQ-010 mem_we  output  1  single-cycle write strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  word address of current write.
REQ-012 mem_wdata  output  8*WORD_BYTES  assembled word.
REQ-013 load_done  output  1  level; end marker received.
REQ-014 frame_err  output  1  sticky; stop-bit or parity failure seen.
REQ-015 overflow  output  1  sticky; word arrived with address space exhausted.
REQ-016 word_count  output  ADDR_WIDTH+1  number of words written since reset/restart.

Function
REQ-017 rx_serial passes through a 2-flop synchronizer before any use; latency counted from synchronized line.
REQ-018 Bit FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START on synchronized falling edge; START re-samples at CLKS_PER_BIT/2; line high there -> back to IDLE (glitch, no error).
REQ-020 DATA samples 8 bits at mid-bit, every CLKS_PER_BIT cycles, LSB first.
REQ-021 PARITY (only when PARITY_EN) samples one bit; mismatch with even parity marks byte bad.
REQ-022 STOP samples mid-bit; low or bad parity -> byte discarded, frame_err set, return to IDLE without waiting for line high.
REQ-023 Good bytes assemble little-endian: first byte -> bits [7:0], byte k -> bits [8k+7:8k].
REQ-024 On WORD_BYTES-th good byte: mem_we high one cycle, mem_wdata = word, mem_addr = current address; address and word_count increment next cycle.
REQ-025 Write occurs at most 2 cycles after the final byte's stop-bit sample.
REQ-026 A discarded byte does not advance byte position; partial word retained.
REQ-027 End marker: word equal to all ones; it is written normally, then load_done set and loader enters DONE.
REQ-028 In DONE, bytes are still received and checked but never written; load_done holds until restart or rst.
REQ-029 Word arriving when word_count = 2^ADDR_WIDTH: no write, overflow set, address does not wrap.
REQ-030 restart: clears address, word_count, byte position, load_done, frame_err, overflow; bit FSM receiving a byte finishes it, byte then discarded.
REQ-031 restart coincident with a write: write completes, then clear takes effect.
REQ-032 mem_we never asserts on consecutive cycles.

Reset
REQ-033 rst asserted: all outputs 0, mem_addr 0, bit FSM IDLE, synchronizer flops 1 (idle line).
REQ-034 rst mid-byte aborts it; partial word lost; no write after deassertion until a new full word arrives.

Structure
REQ-035 Shared package loader_pkg holds bit-FSM state enum, end-marker constant function, and CLKS_PER_BIT helper function.
REQ-036 One sub-module uart_rx_core (synchronizer, bit FSM, baud counter) emitting byte_valid/byte_data/byte_err; word assembly and address logic in uart_mem_loader.

Verification
REQ-037 Send 0x93,0x00,0x10,0x00 at 8680 ns/bit -> one mem_we, addr 0, wdata 0x00100093, word_count 1.
REQ-038 Three words then 0xFF x4 -> writes at addr 0..3, load_done high after 4th write; further 0x13 byte -> no mem_we.
REQ-039 Byte with stop bit forced 0 between bytes 2 and 3 -> frame_err set, word still completes from 4 good bytes.
REQ-040 ADDR_WIDTH=2, send 5 words -> 4 writes, overflow set on 5th, word_count 4.
REQ-041 PARITY_EN=1, byte 0x01 with parity 0 -> discarded, frame_err; parity 1 -> accepted.
REQ-042 rst pulsed mid-data-bit of 2nd byte -> all outputs 0; next 4 good bytes write addr 0.
